// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder constants and sign/magnitude helpers.
package ldpc_pkg;

    localparam int unsigned MSG_W = 8;

    typedef enum logic {
        BANK_IDLE = 1'b0,
        BANK_BUSY = 1'b1
    } bank_state_e;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int unsigned ldpc_log2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // |q| of a sign-extended w-bit value, clamped to 2^(w-1)-1.
    function automatic logic [31:0] sat_abs(input logic [31:0] q, input int unsigned w);
        logic [31:0] lim;
        logic [31:0] a;
        lim = (32'd1 << (w - 1)) - 32'd1;
        a   = q[31] ? (~q + 32'd1) : q;
        return (a > lim) ? lim : a;
    endfunction

    // Negate when s is set, never producing a negative zero.
    function automatic logic [31:0] cond_neg(input logic [31:0] m, input logic s);
        return (s && (m != 32'd0)) ? (~m + 32'd1) : m;
    endfunction

endpackage

// File: rtl/cnu_minsel.sv
// Running min1/min2/argmin update for one incoming magnitude.
module cnu_minsel
    import ldpc_pkg::*;
#(
    parameter int unsigned MAG_W = MSG_W - 1,
    parameter int unsigned CNT_W = 3
) (
    input  logic [MAG_W-1:0] mag,
    input  logic [CNT_W-1:0] cnt,
    input  logic [MAG_W-1:0] min1,
    input  logic [MAG_W-1:0] min2,
    input  logic [CNT_W-1:0] idx,
    output logic [MAG_W-1:0] min1_c,
    output logic [MAG_W-1:0] min2_c,
    output logic [CNT_W-1:0] idx_c
);

    // Strict compares: an equal magnitude never steals idx from an earlier one.
    always_comb begin
        min1_c = min1;
        min2_c = min2;
        idx_c  = idx;
        if (mag < min1) begin
            min2_c = min1;
            min1_c = mag;
            idx_c  = cnt;
        end else if (mag < min2) begin
            min2_c = mag;
        end
    end

endmodule

// File: rtl/cnu_serial.sv
// Serial min-sum check node: collects DC q messages per row, streams DC r messages
// from a second bank while the next row is being collected.
module cnu_serial
    import ldpc_pkg::*;
#(
    parameter int unsigned data_w = MSG_W,
    parameter int unsigned DC     = 6,
    parameter int unsigned OFFSET = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [data_w-1:0] in_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [data_w-1:0] out_r,
    output logic              out_last
);

    localparam int unsigned MAG_W = data_w - 1;
    localparam int unsigned CNT_W = ldpc_log2(DC);
    localparam logic [MAG_W-1:0] MAG_MAX = '1;
    localparam logic [MAG_W-1:0] OFF     = MAG_W'(OFFSET);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(DC - 1);

    // collect side
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [MAG_W-1:0] min1, min1_n, min2, min2_n;
    logic [CNT_W-1:0] idx, idx_n;
    logic [DC-1:0]    signs, signs_n, signs_upd;
    logic             sprod, sprod_n;
    logic             pending, pending_n, in_ready_n;

    // output bank
    bank_state_e      state, state_n;
    logic [CNT_W-1:0] k, k_n, k_inc;
    logic [MAG_W-1:0] b_min1, b_min1_n, b_min2, b_min2_n;
    logic [CNT_W-1:0] b_idx, b_idx_n;
    logic [DC-1:0]    b_signs, b_signs_n;
    logic             b_sprod, b_sprod_n;
    logic             out_valid_n, out_last_n;
    logic [data_w-1:0] out_r_n;

    logic [31:0]      q_ext;
    logic             q_sign;
    logic [MAG_W-1:0] q_mag;
    logic [MAG_W-1:0] upd_min1, upd_min2;
    logic [CNT_W-1:0] upd_idx;
    logic             acc_in, acc_out, last_out, row_done, bank_free;
    logic             xfer_new, xfer_pend, load;
    logic [MAG_W-1:0] src_min1, src_min2;
    logic [CNT_W-1:0] src_idx;
    logic [DC-1:0]    src_signs;
    logic             src_sprod;

    function automatic logic [data_w-1:0] r_value(
        input logic [MAG_W-1:0] m1,
        input logic [MAG_W-1:0] m2,
        input logic [CNT_W-1:0] id,
        input logic [CNT_W-1:0] kk,
        input logic [DC-1:0]    sg,
        input logic             sp
    );
        logic [MAG_W-1:0] m;
        logic [MAG_W-1:0] mo;
        logic             s;
        m  = (kk == id) ? m2 : m1;
        mo = (m > OFF) ? (m - OFF) : '0;
        s  = sp ^ sg[kk];
        return data_w'(cond_neg(32'(mo), s));
    endfunction

    assign q_ext  = {{(32 - data_w){in_q[data_w-1]}}, in_q};
    assign q_sign = in_q[data_w-1];
    assign q_mag  = MAG_W'(sat_abs(q_ext, data_w));

    cnu_minsel #(
        .MAG_W (MAG_W),
        .CNT_W (CNT_W)
    ) u_minsel (
        .mag    (q_mag),
        .cnt    (cnt),
        .min1   (min1),
        .min2   (min2),
        .idx    (idx),
        .min1_c (upd_min1),
        .min2_c (upd_min2),
        .idx_c  (upd_idx)
    );

    assign acc_in    = in_valid && in_ready;
    assign acc_out   = (state == BANK_BUSY) && out_ready;
    assign last_out  = acc_out && out_last;
    assign row_done  = acc_in && (cnt == LAST);
    assign bank_free = (state == BANK_IDLE) || last_out;
    assign xfer_new  = row_done && bank_free;
    assign xfer_pend = pending && last_out;
    assign load      = xfer_new || xfer_pend;
    assign k_inc     = k + CNT_W'(1);

    // A same-edge transfer takes the just-updated row; a pending one takes the parked row.
    always_comb begin
        signs_upd      = signs;
        signs_upd[cnt] = q_sign;
        src_min1       = xfer_new ? upd_min1 : min1;
        src_min2       = xfer_new ? upd_min2 : min2;
        src_idx        = xfer_new ? upd_idx : idx;
        src_signs      = xfer_new ? signs_upd : signs;
        src_sprod      = xfer_new ? (sprod ^ q_sign) : sprod;
    end

    // Next-state for collect side and output bank.
    always_comb begin
        cnt_n       = cnt;
        min1_n      = min1;
        min2_n      = min2;
        idx_n       = idx;
        signs_n     = signs;
        sprod_n     = sprod;
        pending_n   = pending;
        in_ready_n  = in_ready;
        state_n     = state;
        k_n         = k;
        b_min1_n    = b_min1;
        b_min2_n    = b_min2;
        b_idx_n     = b_idx;
        b_signs_n   = b_signs;
        b_sprod_n   = b_sprod;
        out_valid_n = out_valid;
        out_r_n     = out_r;
        out_last_n  = out_last;

        if (acc_in) begin
            cnt_n   = row_done ? '0 : (cnt + CNT_W'(1));
            min1_n  = upd_min1;
            min2_n  = upd_min2;
            idx_n   = upd_idx;
            signs_n = signs_upd;
            sprod_n = sprod ^ q_sign;
            if (row_done && !bank_free) begin
                pending_n  = 1'b1;
                in_ready_n = 1'b0;
            end
        end

        if (load) begin
            min1_n     = MAG_MAX;
            min2_n     = MAG_MAX;
            idx_n      = '0;
            signs_n    = '0;
            sprod_n    = 1'b0;
            pending_n  = 1'b0;
            in_ready_n = 1'b1;
        end

        unique case (state)
            BANK_IDLE: begin
                if (load) begin
                    state_n = BANK_BUSY;
                end
            end
            BANK_BUSY: begin
                if (last_out && !load) begin
                    state_n = BANK_IDLE;
                end
            end
            default: state_n = BANK_IDLE;
        endcase

        if (load) begin
            k_n         = '0;
            b_min1_n    = src_min1;
            b_min2_n    = src_min2;
            b_idx_n     = src_idx;
            b_signs_n   = src_signs;
            b_sprod_n   = src_sprod;
            out_valid_n = 1'b1;
            out_r_n     = r_value(src_min1, src_min2, src_idx, '0, src_signs, src_sprod);
            out_last_n  = (LAST == '0);
        end else if (last_out) begin
            out_valid_n = 1'b0;
            out_r_n     = '0;
            out_last_n  = 1'b0;
        end else if (acc_out) begin
            k_n        = k_inc;
            out_r_n    = r_value(b_min1, b_min2, b_idx, k_inc, b_signs, b_sprod);
            out_last_n = (k_inc == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            min1      <= MAG_MAX;
            min2      <= MAG_MAX;
            idx       <= '0;
            signs     <= '0;
            sprod     <= 1'b0;
            pending   <= 1'b0;
            in_ready  <= 1'b1;
            state     <= BANK_IDLE;
            k         <= '0;
            b_min1    <= MAG_MAX;
            b_min2    <= MAG_MAX;
            b_idx     <= '0;
            b_signs   <= '0;
            b_sprod   <= 1'b0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_last  <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            min1      <= min1_n;
            min2      <= min2_n;
            idx       <= idx_n;
            signs     <= signs_n;
            sprod     <= sprod_n;
            pending   <= pending_n;
            in_ready  <= in_ready_n;
            state     <= state_n;
            k         <= k_n;
            b_min1    <= b_min1_n;
            b_min2    <= b_min2_n;
            b_idx     <= b_idx_n;
            b_signs   <= b_signs_n;
            b_sprod   <= b_sprod_n;
            out_valid <= out_valid_n;
            out_r     <= out_r_n;
            out_last  <= out_last_n;
        end
    end

endmodule

// File: tb/tb_cnu_serial.sv
// Self-checking bench for cnu_serial: plain min-sum instance plus an OFFSET=1 instance.
module tb_cnu_serial;

    localparam int unsigned W  = 8;
    localparam int unsigned DC = 6;

    typedef logic [W-1:0] row_t [DC];

    logic clk = 1'b0;
    logic rst;
    logic iv, ordy, sel;
    logic [W-1:0] iq;

    logic iv0, iv1, ordy0, ordy1, irdy0, irdy1, ov0, ov1, ol0, ol1;
    logic [W-1:0] r0, r1;
    logic irdy, ov, ol;
    logic [W-1:0] orr;

    int total = 0;
    int bad   = 0;
    logic [W:0] exp_q[$];
    int cyc = 0;
    int nout = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    int nacc = 0;

    assign iv0   = iv & ~sel;
    assign iv1   = iv & sel;
    assign ordy0 = ordy & ~sel;
    assign ordy1 = ordy & sel;
    assign irdy  = sel ? irdy1 : irdy0;
    assign ov    = sel ? ov1 : ov0;
    assign ol    = sel ? ol1 : ol0;
    assign orr   = sel ? r1 : r0;

    cnu_serial #(.data_w(W), .DC(DC), .OFFSET(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(irdy0), .in_q(iq),
        .out_valid(ov0), .out_ready(ordy0), .out_r(r0), .out_last(ol0)
    );

    cnu_serial #(.data_w(W), .DC(DC), .OFFSET(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(irdy1), .in_q(iq),
        .out_valid(ov1), .out_ready(ordy1), .out_r(r1), .out_last(ol1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: r_k = product of other signs times min of other magnitudes, minus offset.
    function automatic logic [W-1:0] model_r(input row_t q, input int k, input int off);
        int mag[DC];
        bit sg[DC];
        int m, mo, v;
        bit s;
        m = 1000;
        s = 1'b0;
        for (int j = 0; j < DC; j++) begin
            v = int'($signed(q[j]));
            sg[j] = q[j][W-1];
            mag[j] = (v < 0) ? -v : v;
            if (mag[j] > 127) mag[j] = 127;
        end
        for (int j = 0; j < DC; j++) begin
            if (j != k) begin
                if (mag[j] < m) m = mag[j];
                s = s ^ sg[j];
            end
        end
        mo = (m > off) ? m - off : 0;
        v = (s && mo != 0) ? -mo : mo;
        return W'(v);
    endfunction

    task automatic push_model(input row_t q, input int off);
        for (int k = 0; k < DC; k++) exp_q.push_back({(k == DC - 1), model_r(q, k, off)});
    endtask

    task automatic push_list(input row_t e);
        for (int k = 0; k < DC; k++) exp_q.push_back({(k == DC - 1), e[k]});
    endtask

    task automatic send_q(input logic [W-1:0] q);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        iv = 1'b1;
        iq = q;
        while (!done) begin
            @(negedge clk);
            done = irdy;
            @(posedge clk);
            #1;
            n++;
            if (!done && n >= 300) begin
                chk("send_timeout", 32'(n), 32'd0);
                done = 1'b1;
            end
        end
    endtask

    task automatic send_row(input row_t q);
        for (int i = 0; i < DC; i++) send_q(q[i]);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted output is checked against the oldest expectation.
    always @(negedge clk) begin
        logic [W:0] e;
        if (!rst && iv && irdy) nacc++;
        if (!rst && ov && ordy) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_out: observed=%0h expected=none", orr);
            end else begin
                e = exp_q.pop_front();
                chk("out_r", 32'(orr), 32'(e[W-1:0]));
                chk("out_last", 32'(ol), 32'(e[W]));
            end
            nout++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
        end
    end

    initial begin
        row_t ex1, ex1_exp, ex2, ex2_exp, ex3, ex3_exp, rr;
        row_t rows[4];
        int t0;

        ex1     = '{8'(5), 8'(-3), 8'(7), 8'(2), 8'(-9), 8'(4)};
        ex1_exp = '{8'(2), 8'(-2), 8'(2), 8'(3), 8'(-2), 8'(2)};
        ex2     = '{8'(-128), 8'(10), 8'(10), 8'(10), 8'(10), 8'(10)};
        ex2_exp = '{8'(10), 8'(-10), 8'(-10), 8'(-10), 8'(-10), 8'(-10)};
        ex3     = '{8'(0), 8'(1), 8'(5), 8'(-6), 8'(7), 8'(-8)};
        ex3_exp = '{8'(0), 8'(0), 8'(0), 8'(0), 8'(0), 8'(0)};

        rst = 1'b1; iv = 1'b0; iq = '0; ordy = 1'b1; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_out_r", 32'(r0), 32'd0);
        chk("rst_out_last", 32'(ol0), 32'd0);
        chk("rst_in_ready", 32'(irdy0), 32'd1);
        chk("rst_in_ready_off", 32'(irdy1), 32'd1);
        chk("rst_out_valid_off", 32'(ov1), 32'd0);
        @(posedge clk);
        #1;

        // basic row with first-output latency
        push_list(ex1_exp);
        for (int i = 0; i < DC - 1; i++) send_q(ex1[i]);
        chk("no_early_valid", 32'(ov), 32'd0);
        send_q(ex1[DC-1]);
        chk("first_r_latency", 32'(ov), 32'd1);
        iv = 1'b0;
        wait_drain();

        // saturation and tie on idx
        push_list(ex2_exp);
        send_row(ex2);
        iv = 1'b0;
        wait_drain();

        // offset build, zero magnitudes never become negative
        sel = 1'b1;
        push_list(ex3_exp);
        send_row(ex3);
        iv = 1'b0;
        wait_drain();
        sel = 1'b0;
        @(posedge clk);
        #1;

        // backpressure: one row in the bank, one parked, then in_ready drops
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < DC; j++) rows[r][j] = W'($urandom);
            push_model(rows[r], 0);
        end
        ordy = 1'b0;
        nacc = 0;
        fork
            begin
                send_row(rows[0]);
                send_row(rows[1]);
                send_row(rows[2]);
                iv = 1'b0;
            end
            begin
                repeat (20) @(posedge clk);
                @(negedge clk);
                chk("bp_accepts", 32'(nacc), 32'd12);
                chk("bp_in_ready", 32'(irdy), 32'd0);
                @(posedge clk);
                #1;
                ordy = 1'b1;
            end
        join
        wait_drain();

        // full throughput across 4 rows
        nout = 0;
        first_cyc = -1;
        last_cyc = -1;
        t0 = cyc;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < DC; j++) rows[r][j] = W'($urandom);
            push_model(rows[r], 0);
            send_row(rows[r]);
        end
        chk("tp_in_no_stall", 32'(cyc - t0), 32'd24);
        iv = 1'b0;
        wait_drain();
        chk("tp_count", 32'(nout), 32'd24);
        chk("tp_no_bubbles", 32'(last_cyc - first_cyc), 32'd23);

        // reset mid-row discards the partial row
        for (int i = 0; i < 3; i++) send_q(W'($urandom));
        iv = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", 32'(ov), 32'd0);
        chk("midrst_in_ready", 32'(irdy), 32'd1);
        for (int j = 0; j < DC; j++) rr[j] = W'($urandom);
        rr[2] = 8'(-128);
        push_model(rr, 0);
        send_row(rr);
        iv = 1'b0;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
